adder_op_sequencer: RTL and testbench
=====================================

// Module: adder_op_sequencer
// PURPOSE
//  - Control stage wrapped around the registered 8-bit ripple adder (adder_top).
//  - Upstream: buffers operand requests in a FIFO and drives the adder's a/b/cin.
//  - Holds each operand set stable for the adder's full settle time.
//  - Downstream: captures {cout,s} and returns it with a valid/ready handshake.
//  - Add/subtract select: for subtract, b is inverted and cin=1 (two's complement).
// PARAMETERS
//  WIDTH    8  operand/sum width; must match the adder instance
//  LATENCY  8  cycles the adder needs from stable inputs to valid s/cout; >=1
//  DEPTH    4  input FIFO entries; power of two, >=2
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      synchronous, active-high reset
//  in_valid  in   1      operand request valid
//  in_ready  out  1      = !fifo_full && !rst
//  in_a      in   WIDTH  operand a
//  in_b      in   WIDTH  operand b
//  in_sub    in   1      1 = a-b, 0 = a+b
//  add_a     out  WIDTH  to adder a
//  add_b     out  WIDTH  to adder b (in_b or ~in_b)
//  add_cin   out  1      to adder cin (= in_sub)
//  add_s     in   WIDTH  from adder s
//  add_cout  in   1      from adder cout
//  out_valid out  1      result valid
//  out_ready in   1      result accepted
//  out_sum   out  WIDTH  captured s
//  out_cout  out  1      captured cout (sub: 1 = no borrow, a>=b unsigned)
//  out_ovf   out  1      signed overflow of the operation
//  busy      out  1      state != IDLE || fifo not empty
// BEHAVIOUR
//  - Reset: FIFO empty; state IDLE; add_a/add_b/add_cin, out_* and busy = 0.
//    in_ready=0 while rst is high, 1 on the first cycle after.
//  - Push: in_valid && in_ready at an edge. No push when full, even if a pop
//    occurs on the same edge. Strict FIFO order.
//  - FSM:
//    IDLE:  FIFO non-empty -> pop, register add_a/add_b/add_cin,
//           load cnt=LATENCY-1, go DRIVE.
//    DRIVE: add_* held constant. cnt decrements each cycle. At cnt==0,
//           capture out_sum=add_s, out_cout=add_cout, compute out_ovf, set
//           out_valid=1, go DONE. DRIVE lasts exactly LATENCY cycles.
//    DONE:  out_* held while out_ready=0.
//           out_ready && FIFO non-empty -> pop next op, go DRIVE on the same
//           edge (back-to-back).
//           out_ready && FIFO empty -> out_valid=0, go IDLE.
//  - Latency: op accepted at edge E -> out_valid rises at edge E+LATENCY+1
//    when the sequencer is idle.
//  - Throughput: one op per LATENCY+1 cycles with out_ready held high.
//  - Overflow: out_ovf = (add_a[W-1]==add_b[W-1]) && (add_s[W-1]!=add_a[W-1]).
//    Computed from the driven (already inverted) operands.
//  - Reset mid-DRIVE/DONE: the op in flight and all FIFO contents are discarded.
//    No partial result is emitted.
// CONFIGURATION
//  ADDSEQ_STATS_EN defined:
//   - Adds output op_count[15:0], cleared by rst.
//   - +1 on each result handshake (out_valid && out_ready); wraps 0xFFFF->0.
//  ADDSEQ_STATS_EN undefined:
//   - Port and counter absent; all other behaviour identical.
// TESTING (WIDTH=8, LATENCY=8, DEPTH=4; adder_top instance as the DUT load)
//  1 Reset held 3 cycles -> all outputs 0; in_ready=1 one cycle after rst falls.
//  2 0x7F+0x01 add at edge E -> out_valid rises at E+9;
//    out_sum=0x80, out_cout=0, out_ovf=1.
//  3 0x05-0x07 sub -> add_b=0xF8, add_cin=1; out_sum=0xFE, out_cout=0, out_ovf=0.
//  4 0xFF+0x01 add -> out_sum=0x00, out_cout=1, out_ovf=0;
//    0x80-0x01 sub -> out_sum=0x7F, out_cout=1, out_ovf=1.
//  5 out_ready=0, push 6 ops back-to-back:
//    - 1st op reaches DONE; 4 ops sit in the FIFO; in_ready=0 with 6th pending.
//    - Raise out_ready: results appear in push order, one every 9 cycles.
//    - op_count=6 when stats are enabled.
//  6 rst pulsed mid-DRIVE with 2 ops queued -> out_valid never asserts;
//    busy=0; next op completes normally with correct values.

Source files
------------

// File: rtl/adder_op_sequencer.sv
// Control stage around a registered ripple adder: buffers operand requests, holds them
// for the adder's settle time and returns {cout,sum,ovf}. Define ADDSEQ_STATS_EN for op_count.
module adder_op_sequencer #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 8,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
`ifdef ADDSEQ_STATS_EN
  output logic             busy,
  output logic [15:0]      op_count
`else
  output logic             busy
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  typedef struct packed {
    logic             sub;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d, out_sum_q, out_sum_d;
  logic             add_cin_q, add_cin_d;
  logic             out_valid_q, out_valid_d, out_cout_q, out_cout_d, out_ovf_q, out_ovf_d;
  logic             fifo_full, fifo_empty, push, pop;

  always_comb begin
    fifo_full   = (count_q == (AW+1)'(DEPTH));
    fifo_empty  = (count_q == '0);
    in_ready    = !fifo_full && !rst;
    push        = in_valid && in_ready;
    pop         = 1'b0;
    head        = mem[rd_ptr_q];
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          out_sum_d   = add_s;
          out_cout_d  = add_cout;
          // Overflow judged on the operands actually presented to the adder.
          out_ovf_d   = (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) &&
                        (add_s[WIDTH-1] != add_a_q[WIDTH-1]);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      add_a_d   = head.a;
      add_b_d   = head.sub ? ~head.b : head.b;
      add_cin_d = head.sub;
      cnt_d     = CW'(LATENCY - 1);
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)
      count_d = count_q + (AW+1)'(1);
    else if (pop && !push)
      count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= '{sub: in_sub, b: in_b, a: in_a};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

`ifdef ADDSEQ_STATS_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (out_valid_q && out_ready)
      op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) op_count_q <= '0;
    else     op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Bench for adder_op_sequencer: behavioural adder load, arithmetic reference model,
// scoreboard queue filled by the driver and drained by an independent monitor.
module tb_adder_op_sequencer;
  localparam int W = 8;
  localparam int L = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready, add_cin, add_cout, out_valid, out_cout, out_ovf, busy;
  logic [W-1:0] add_a, add_b, add_s, out_sum;
`ifdef ADDSEQ_STATS_EN
  logic [15:0]  op_count;
`endif

  adder_op_sequencer #(.WIDTH(W), .LATENCY(L), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
`ifdef ADDSEQ_STATS_EN
    .busy(busy), .op_count(op_count)
`else
    .busy(busy)
`endif
  );

  always #5 clk = ~clk;

  // Registered adder load: result settles L-1 edges after its inputs change.
  logic [W:0] add_pipe [L-1];
  always @(posedge clk) begin
    add_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    for (int i = 1; i < L-1; i++) add_pipe[i] <= add_pipe[i-1];
  end
  assign add_s    = add_pipe[L-2][W-1:0];
  assign add_cout = add_pipe[L-2][W];

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic check_tput = 1'b0;
  int   tput_n = 0;
  int   last_hs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    res_t r;
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sbv = int'($signed(b));
    int ures = sub ? ua - ub : ua + ub;
    int sres = sub ? sa - sbv : sa + sbv;
    r.sum  = ures[W-1:0];
    r.cout = sub ? (ua >= ub) : (ures > 255);
    r.ovf  = (sres > 127) || (sres < -128);
    return r;
  endfunction

  // Monitor: one comparison per result handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got sum=%h cout=%b ovf=%b, required no result", out_sum, out_cout, out_ovf);
      end else begin
        res_t e;
        e = sb.pop_front();
        if (out_sum !== e.sum || out_cout !== e.cout || out_ovf !== e.ovf) begin
          n_fail++;
          $display("FAIL result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                   out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
        end else
          $display("result ok: sum=%h cout=%b ovf=%b", out_sum, out_cout, out_ovf);
      end
      if (check_tput) begin
        if (tput_n > 0) begin
          n_checks++;
          if (cyc - last_hs != L + 1) begin
            n_fail++;
            $display("FAIL throughput: got spacing %0d, required %0d", cyc - last_hs, L + 1);
          end
        end
        tput_n++;
        last_hs = cyc;
      end else
        tput_n = 0;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int waited = 0;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
      in_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk);
    sb.push_back(ref_op(a, b, sub));
    $display("push a=%h b=%h sub=%b", a, b, sub);
    #1 acc_cyc = cyc;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || busy || out_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (sb.size() != 0 || busy) begin
      n_fail++;
      $display("FAIL drain: pending=%0d busy=%b, required 0/0", sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    sb.delete();
    repeat (cycles) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int n;
    // Reset state.
    @(posedge clk); #1;
    do_reset(3);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b a=%h b=%h cin=%b v=%b s=%h c=%b o=%b busy=%b, required all 0",
               in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf, busy);
    end
`ifdef ADDSEQ_STATS_EN
    n_checks++;
    if (op_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_op_count: got %0d, required 0", op_count);
    end
`endif
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL in_ready_after_reset: got %b, required 1", in_ready);
    end
    @(posedge clk); #1;

    // Latency from acceptance to out_valid.
    out_ready = 1'b1;
    push_op(8'h7F, 8'h01, 1'b0);
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (!out_valid || cyc - acc_cyc != L + 1) begin
      n_fail++; $display("FAIL latency: got %0d cycles (valid=%b), required %0d", cyc - acc_cyc, out_valid, L + 1);
    end
    @(posedge clk); #1;
    drain();

    // Subtract drives inverted b and cin=1.
    push_op(8'h05, 8'h07, 1'b1);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (add_a !== 8'h05 || add_b !== 8'hF8 || add_cin !== 1'b1) begin
      n_fail++; $display("FAIL sub_drive: got a=%h b=%h cin=%b, required a=05 b=f8 cin=1", add_a, add_b, add_cin);
    end
    @(posedge clk); #1;
    drain();

    push_op(8'hFF, 8'h01, 1'b0);
    push_op(8'h80, 8'h01, 1'b1);
    drain();

    // Backpressure: fill the FIFO, then release and check spacing.
    do_reset(2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_op(W'($urandom), W'($urandom), 1'($urandom));
    ra = W'($urandom); rb = W'($urandom);
    in_a = ra; in_b = rb; in_sub = 1'b1; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (!out_valid || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL fifo_full: got valid=%b in_ready=%b busy=%b, required 1/0/1", out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    check_tput = 1'b1;
    out_ready = 1'b1;
    push_op(ra, rb, 1'b1);
    drain();
    check_tput = 1'b0;
`ifdef ADDSEQ_STATS_EN
    n_checks++;
    if (op_count !== 16'd6) begin
      n_fail++; $display("FAIL op_count: got %0d, required 6", op_count);
    end
`endif

    // Reset while an op is in flight with two more queued.
    push_op(8'h11, 8'h22, 1'b0);
    push_op(8'h33, 8'h44, 1'b1);
    push_op(8'h55, 8'h66, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    do_reset(1);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_after_reset: got %b, required 0", busy);
    end
    n = 0;
    repeat (20) begin @(negedge clk); if (out_valid) n++; end
    n_checks++;
    if (n != 0) begin
      n_fail++; $display("FAIL flushed_result: got out_valid for %0d cycles, required 0", n);
    end
    @(posedge clk); #1;
    push_op(8'h9C, 8'h3A, 1'b1);
    drain();

    // Random traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          push_op(W'($urandom), W'($urandom), 1'($urandom));
          in_valid = 1'b0;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        check_tput = 1'b0;
      end
      begin
        repeat (600) begin
          @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_any
    disable fork;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
